// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_fetch_ctrl_if: ROM, decode, redirect/halt and debug-read signals    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface imem_fetch_ctrl_if;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        dbg_req;
  logic [9:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  // master: the fetch controller; slave: ROM, decode and debug requester
  modport master (
    output rom_addr, input rom_data,
    output if_valid, input if_ready, output if_instr, output if_pc,
    input redirect, input redirect_pc, input halt, output halted,
    input dbg_req, input dbg_addr, output dbg_ack, output dbg_data
  );

  modport slave (
    input rom_addr, output rom_data,
    input if_valid, output if_ready, input if_instr, input if_pc,
    output redirect, output redirect_pc, output halt, input halted,
    output dbg_req, output dbg_addr, input dbg_ack, input dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_fetch_ctrl: PC sequencer + 2-entry fetch queue with debug sharing   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DBG_MAX_WAIT = 3
) (
  input  wire logic            clk,
  input  wire logic            rst,
  imem_fetch_ctrl_if.master    bus
);

  localparam logic [1:0] WAIT_LIMIT = 2'(DBG_MAX_WAIT);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FULL  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic [31:0] r_q0_pc, r_q0_instr, r_q1_pc, r_q1_instr;
  logic [1:0]  r_dbg_wait;
  logic        r_dbg_ack;
  logic [31:0] r_dbg_data;

  logic        w_deq, w_fetch_ok, w_grant, w_fetch;
  logic [1:0]  w_count_next, w_slot;
  logic        w_unused;

  assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

  always_comb begin
    w_deq        = (r_count != 2'd0) && bus.if_ready;
    w_fetch_ok   = (r_state == ST_FETCH) && ((r_count != 2'd2) || w_deq)
                   && !bus.redirect && !bus.halt;
    // a starved debug request wins once it has waited WAIT_LIMIT fetch cycles
    w_grant      = bus.dbg_req && !r_dbg_ack
                   && (!w_fetch_ok || (r_dbg_wait == WAIT_LIMIT));
    w_fetch      = w_fetch_ok && !w_grant;
    w_count_next = bus.redirect ? 2'd0
                 : r_count - {1'b0, w_deq} + {1'b0, w_fetch};
    w_slot       = w_deq ? r_count - 2'd1 : r_count;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.halt) begin
      w_state_next = ST_HALT;
    end else begin
      case (r_state)
        ST_FETCH: if (w_count_next == 2'd2 && !w_deq) w_state_next = ST_FULL;
        ST_FULL:  if (w_deq || bus.redirect)         w_state_next = ST_FETCH;
        ST_HALT:  w_state_next = ST_FETCH;
        default:  w_state_next = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_count    <= 2'd0;
      r_q0_pc    <= 32'd0;
      r_q0_instr <= 32'd0;
      r_q1_pc    <= 32'd0;
      r_q1_instr <= 32'd0;
      r_dbg_wait <= 2'd0;
      r_dbg_ack  <= 1'b0;
      r_dbg_data <= 32'd0;
    end else begin
      r_dbg_ack <= w_grant;
      if (w_grant) r_dbg_data <= bus.rom_data;

      if (!bus.dbg_req || w_grant)
        r_dbg_wait <= 2'd0;
      else if (w_fetch && r_dbg_wait != WAIT_LIMIT)
        r_dbg_wait <= r_dbg_wait + 2'd1;

      r_count <= w_count_next;
      if (w_deq) begin
        r_q0_pc    <= r_q1_pc;
        r_q0_instr <= r_q1_instr;
      end
      // the write into the post-dequeue tail slot overrides the shift above
      if (w_fetch) begin
        if (w_slot[0]) begin
          r_q1_pc    <= r_pc;
          r_q1_instr <= bus.rom_data;
        end else begin
          r_q0_pc    <= r_pc;
          r_q0_instr <= bus.rom_data;
        end
      end

      if (bus.redirect)   r_pc <= {bus.redirect_pc[31:2], 2'b00};
      else if (w_fetch)   r_pc <= r_pc + 32'd4;
    end
  end

  assign bus.rom_addr = w_grant ? bus.dbg_addr : r_pc[11:2];
  assign bus.if_valid = (r_count != 2'd0);
  assign bus.if_pc    = r_q0_pc;
  assign bus.if_instr = r_q0_instr;
  assign bus.halted   = (r_state == ST_HALT) && (r_count == 2'd0);
  assign bus.dbg_ack  = r_dbg_ack;
  assign bus.dbg_data = r_dbg_data;

endmodule
`default_nettype wire
